pht_update_scheduler: RTL and testbench

Sequences all writes into the 4-bank, 256-entry two-bit-counter pattern history table. It runs the post-reset initialization sweep so that no bulk reset loop sits on the counter arrays. It then accepts resolved-branch updates from two branch-resolution requesters, buffers them in a small FIFO, and drains one update per cycle onto the PHT write port with saturating next-state arithmetic. It sits between the back-end branch units and the PHT in the IF stage.

---
 rtl/pht_update_scheduler_pkg.sv | 44 ++++
 rtl/pht_upd_fifo.sv | 62 ++++++
 rtl/pht_update_scheduler.sv | 158 +++++++++++++++
 tb/tb_pht_update_scheduler.sv | 309 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pht_update_scheduler_pkg.sv
// Shared PHT definitions: table geometry, bank field position, the index hash,
// the init counter value and the update-buffer entry layout. The PHT read side
// imports the same hash so read and write mappings cannot diverge.
package pht_update_scheduler_pkg;

    localparam int ITEM_NUM   = 256;
    localparam int IW         = $clog2(ITEM_NUM);
    localparam int NUM_BANKS  = 4;
    localparam int FIFO_DEPTH = 4;
    localparam int BANK_LSB   = 2;
    localparam int BANK_MSB   = 3;

    localparam logic [1:0] INIT_CNT = 2'b10;

    typedef enum logic {
        ST_INIT,
        ST_RUN
    } sched_state_t;

    // One buffered update: target bank, entry index and the already-computed
    // counter value to write.
    typedef struct packed {
        logic [1:0]    bank;
        logic [IW-1:0] index;
        logic [1:0]    next;
    } upd_entry_t;

    localparam int ENTRY_W = $bits(upd_entry_t);

    // Index hash. The argument is the address field vaddr[2*IW+3:4]; the low
    // half is folded with the high half.
    function automatic logic [IW-1:0] pht_index(input logic [2*IW-1:0] hash_bits);
        return hash_bits[IW-1:0] ^ hash_bits[2*IW-1:IW];
    endfunction

    // Saturating two-bit counter step.
    function automatic logic [1:0] sat_next(input logic [1:0] count, input logic taken);
        if (taken) begin
            return (count == 2'd3) ? 2'd3 : count + 2'd1;
        end
        return (count == 2'd0) ? 2'd0 : count - 2'd1;
    endfunction

endpackage

// File: rtl/pht_upd_fifo.sv
// Small synchronous FIFO with a two-wide push and a one-wide pop. When both
// pushes fire, data0 lands ahead of data1. Full/empty come from a separate
// occupancy counter so the pointers can simply wrap.
module pht_upd_fifo #(
    parameter int WIDTH = 12,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push0,
    input  logic [WIDTH-1:0]         data0,
    input  logic                     push1,
    input  logic [WIDTH-1:0]         data1,
    input  logic                     pop,
    output logic [WIDTH-1:0]         head,
    output logic [$clog2(DEPTH):0]   count,
    output logic [$clog2(DEPTH):0]   free
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wptr;
    logic [AW-1:0]    rptr;
    logic [AW-1:0]    wptr_second;
    logic [AW:0]      occ;
    logic [AW:0]      push_num;

    // A lone push1 takes the slot at wptr; it only moves up when push0 also fires.
    assign wptr_second = push0 ? wptr + AW'(1) : wptr;
    assign push_num    = (AW+1)'(push0) + (AW+1)'(push1);

    // Storage writes; contents need no reset because occupancy gates every read.
    always_ff @(posedge clk) begin
        if (push0) begin
            mem[wptr] <= data0;
        end
        if (push1) begin
            mem[wptr_second] <= data1;
        end
    end

    // Pointer and occupancy bookkeeping.
    always_ff @(posedge clk) begin
        if (!rst) begin
            wptr <= '0;
            rptr <= '0;
            occ  <= '0;
        end else begin
            wptr <= wptr + AW'(push_num);
            if (pop) begin
                rptr <= rptr + AW'(1);
            end
            occ <= occ + push_num - (AW+1)'(pop);
        end
    end

    assign head  = mem[rptr];
    assign count = occ;
    assign free  = (AW+1)'(DEPTH) - occ;

endmodule

// File: rtl/pht_update_scheduler.sv
// Owns the PHT write port: runs the post-reset init sweep, then accepts
// resolved-branch updates from two requesters, buffers them and writes one
// saturated counter value per cycle.
module pht_update_scheduler
    import pht_update_scheduler_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 upd0_valid,
    input  logic [31:0]          upd0_vaddr,
    input  logic [1:0]           upd0_count,
    input  logic                 upd0_taken,
    input  logic                 upd1_valid,
    input  logic [31:0]          upd1_vaddr,
    input  logic [1:0]           upd1_count,
    input  logic                 upd1_taken,
    output logic                 upd0_ready,
    output logic                 upd1_ready,
    output logic [NUM_BANKS-1:0] pht_wen,
    output logic [IW-1:0]        pht_waddr,
    output logic [1:0]           pht_wdata,
    output logic                 pht_wvld,
    output logic                 init_busy
);

    localparam int FA = $clog2(FIFO_DEPTH);

    sched_state_t         state;
    sched_state_t         state_next;
    logic [IW:0]          sweep_addr;
    logic                 sweep_done;
    upd_entry_t           entry0;
    upd_entry_t           entry1;
    upd_entry_t           head;
    logic [ENTRY_W-1:0]   head_bits;
    logic [FA:0]          fifo_count;
    logic [FA:0]          fifo_free;
    logic                 push0;
    logic                 push1;
    logic                 pop;
    logic [NUM_BANKS-1:0] wen_d;
    logic [IW-1:0]        waddr_d;
    logic [1:0]           wdata_d;
    logic                 wvld_d;
    logic                 unused_vaddr_bits;

    // The top bit of the sweep counter marks that every entry has been written.
    assign sweep_done = sweep_addr[IW];

    assign entry0 = '{bank:  upd0_vaddr[BANK_MSB:BANK_LSB],
                      index: pht_index(upd0_vaddr[2*IW+3:4]),
                      next:  sat_next(upd0_count, upd0_taken)};
    assign entry1 = '{bank:  upd1_vaddr[BANK_MSB:BANK_LSB],
                      index: pht_index(upd1_vaddr[2*IW+3:4]),
                      next:  sat_next(upd1_count, upd1_taken)};

    assign push0 = upd0_valid & upd0_ready;
    assign push1 = upd1_valid & upd1_ready;
    assign head  = upd_entry_t'(head_bits);

    assign unused_vaddr_bits = ^{upd0_vaddr[31:2*IW+4], upd0_vaddr[1:0],
                                 upd1_vaddr[31:2*IW+4], upd1_vaddr[1:0]};

    pht_upd_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push0 (push0),
        .data0 (entry0),
        .push1 (push1),
        .data1 (entry1),
        .pop   (pop),
        .head  (head_bits),
        .count (fifo_count),
        .free  (fifo_free)
    );

    // State register: every reset restarts the init sweep.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= ST_INIT;
        end else begin
            state <= state_next;
        end
    end

    // Leave INIT one cycle after the last sweep write was issued; RUN is terminal.
    always_comb begin
        state_next = state;
        case (state)
            ST_INIT: if (sweep_done) state_next = ST_RUN;
            ST_RUN:  state_next = ST_RUN;
            default: state_next = ST_INIT;
        endcase
    end

    // Per-state outputs: readies, FIFO pop and the next write-port values.
    always_comb begin
        init_busy  = 1'b0;
        upd0_ready = 1'b0;
        upd1_ready = 1'b0;
        pop        = 1'b0;
        wen_d      = '0;
        waddr_d    = '0;
        wdata_d    = '0;
        wvld_d     = 1'b0;
        case (state)
            ST_INIT: begin
                init_busy = 1'b1;
                if (!sweep_done) begin
                    wen_d   = '1;
                    waddr_d = sweep_addr[IW-1:0];
                    wdata_d = INIT_CNT;
                end
            end
            ST_RUN: begin
                upd0_ready = (fifo_free != '0);
                upd1_ready = (fifo_free >= (FA+1)'(2)) ||
                             ((fifo_free == (FA+1)'(1)) && !upd0_valid);
                pop        = (fifo_count != '0);
                if (pop) begin
                    wen_d   = NUM_BANKS'(1) << head.bank;
                    waddr_d = head.index;
                    wdata_d = head.next;
                    wvld_d  = 1'b1;
                end
            end
            default: ;
        endcase
    end

    // Sweep address counter, running only while the sweep is in progress.
    always_ff @(posedge clk) begin
        if (!rst) begin
            sweep_addr <= '0;
        end else if (state == ST_INIT && !sweep_done) begin
            sweep_addr <= sweep_addr + (IW+1)'(1);
        end
    end

    // Registered PHT write port.
    always_ff @(posedge clk) begin
        if (!rst) begin
            pht_wen   <= '0;
            pht_waddr <= '0;
            pht_wdata <= '0;
            pht_wvld  <= 1'b0;
        end else begin
            pht_wen   <= wen_d;
            pht_waddr <= waddr_d;
            pht_wdata <= wdata_d;
            pht_wvld  <= wvld_d;
        end
    end

endmodule

// File: tb/tb_pht_update_scheduler.sv
// Bench for pht_update_scheduler: a queue-based reference model predicts every
// write-port value, readies and init_busy; directed sections pin literals.
module tb_pht_update_scheduler;

    localparam int ITEMS = 256;
    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        upd0_valid = 1'b0;
    logic [31:0] upd0_vaddr = '0;
    logic [1:0]  upd0_count = '0;
    logic        upd0_taken = 1'b0;
    logic        upd1_valid = 1'b0;
    logic [31:0] upd1_vaddr = '0;
    logic [1:0]  upd1_count = '0;
    logic        upd1_taken = 1'b0;
    logic        upd0_ready;
    logic        upd1_ready;
    logic [3:0]  pht_wen;
    logic [7:0]  pht_waddr;
    logic [1:0]  pht_wdata;
    logic        pht_wvld;
    logic        init_busy;

    int n_checks = 0;
    int n_errors = 0;
    int acc_cnt  = 0;
    int wr_cnt   = 0;
    bit check_en = 1'b0;

    always #5 clk = ~clk;

    pht_update_scheduler dut (
        .clk        (clk),
        .rst        (rst),
        .upd0_valid (upd0_valid),
        .upd0_vaddr (upd0_vaddr),
        .upd0_count (upd0_count),
        .upd0_taken (upd0_taken),
        .upd1_valid (upd1_valid),
        .upd1_vaddr (upd1_vaddr),
        .upd1_count (upd1_count),
        .upd1_taken (upd1_taken),
        .upd0_ready (upd0_ready),
        .upd1_ready (upd1_ready),
        .pht_wen    (pht_wen),
        .pht_waddr  (pht_waddr),
        .pht_wdata  (pht_wdata),
        .pht_wvld   (pht_wvld),
        .init_busy  (init_busy)
    );

    typedef struct {
        logic [3:0] wen;
        logic [7:0] addr;
        logic [1:0] data;
    } wr_t;

    wr_t        model_q[$];
    wr_t        mdl_e;
    bit         m_busy = 1'b1;
    int         m_sweep = 0;
    bit         m_r0;
    bit         m_r1;
    logic [3:0] exp_wen = '0;
    logic [7:0] exp_waddr = '0;
    logic [1:0] exp_wdata = '0;
    logic       exp_wvld = 1'b0;

    // The write an accepted request must eventually produce.
    function automatic wr_t model_write(input logic [31:0] a, input logic [1:0] c, input logic t);
        wr_t w;
        int  n;
        w.wen  = 4'(1 << ((a >> 2) % 4));
        w.addr = 8'(((a >> 4) ^ (a >> 12)) % 256);
        n = t ? int'(c) + 1 : int'(c) - 1;
        if (n > 3) n = 3;
        if (n < 0) n = 0;
        w.data = 2'(n);
        return w;
    endfunction

    function automatic logic exp_rdy0();
        return !m_busy && (DEPTH - model_q.size()) >= 1;
    endfunction

    function automatic logic exp_rdy1();
        int fr;
        fr = DEPTH - model_q.size();
        return !m_busy && (fr >= 2 || (fr == 1 && !upd0_valid));
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_errors++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, actual, expected, $time);
        end
    endtask

    // Reference model: advance one clock of sweep / buffer behaviour.
    always @(posedge clk) begin
        if (!rst) begin
            model_q.delete();
            m_busy  = 1'b1;
            m_sweep = 0;
            exp_wen = '0;
        end else if (m_busy) begin
            if (m_sweep < ITEMS) begin
                exp_wen   = 4'hF;
                exp_waddr = 8'(m_sweep);
                exp_wdata = 2'b10;
                exp_wvld  = 1'b0;
                m_sweep++;
            end else begin
                m_busy  = 1'b0;
                exp_wen = '0;
            end
        end else begin
            m_r0 = exp_rdy0();
            m_r1 = exp_rdy1();
            if (model_q.size() > 0) begin
                mdl_e     = model_q.pop_front();
                exp_wen   = mdl_e.wen;
                exp_waddr = mdl_e.addr;
                exp_wdata = mdl_e.data;
                exp_wvld  = 1'b1;
            end else begin
                exp_wen = '0;
            end
            if (upd0_valid && m_r0) model_q.push_back(model_write(upd0_vaddr, upd0_count, upd0_taken));
            if (upd1_valid && m_r1) model_q.push_back(model_write(upd1_vaddr, upd1_count, upd1_taken));
        end
    end

    // Compare DUT against the model mid-cycle, and count handshakes and writes.
    always @(negedge clk) begin
        if (check_en) begin
            checkOutput("pht_wen", pht_wen, exp_wen);
            if (exp_wen != 0) begin
                checkOutput("pht_waddr", pht_waddr, exp_waddr);
                checkOutput("pht_wdata", pht_wdata, exp_wdata);
                checkOutput("pht_wvld", pht_wvld, exp_wvld);
            end
            checkOutput("init_busy", init_busy, m_busy);
            checkOutput("upd0_ready", upd0_ready, exp_rdy0());
            checkOutput("upd1_ready", upd1_ready, exp_rdy1());
            if (upd0_valid && upd0_ready) acc_cnt++;
            if (upd1_valid && upd1_ready) acc_cnt++;
            if (pht_wvld && pht_wen != 0) wr_cnt++;
        end
    end

    task automatic setPorts(input logic v0, input logic [31:0] a0, input logic [1:0] c0, input logic t0,
                            input logic v1, input logic [31:0] a1, input logic [1:0] c1, input logic t1);
        upd0_valid = v0; upd0_vaddr = a0; upd0_count = c0; upd0_taken = t0;
        upd1_valid = v1; upd1_vaddr = a1; upd1_count = c1; upd1_taken = t1;
    endtask

    task automatic applyStimulus(input logic v0, input logic [31:0] a0, input logic [1:0] c0, input logic t0,
                                 input logic v1, input logic [31:0] a1, input logic [1:0] c1, input logic t1);
        setPorts(v0, a0, c0, t0, v1, a1, c1, t1);
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        upd0_valid = 1'b0;
        upd1_valid = 1'b0;
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic randomPair(input logic v0, input logic v1);
        applyStimulus(v0, $urandom, 2'($urandom), 1'($urandom),
                      v1, $urandom, 2'($urandom), 1'($urandom));
    endtask

    // Follow the sweep: 256 writes of INIT_CNT in address order, then both readies.
    task automatic waitInit();
        int f_cycles = 0;
        bit fell = 1'b0;
        for (int i = 0; i < ITEMS + 20 && !fell; i++) begin
            @(negedge clk);
            if (init_busy === 1'b0) begin
                fell = 1'b1;
                checkOutput("rdy0_at_init_done", upd0_ready, 1);
                checkOutput("rdy1_at_init_done", upd1_ready, 1);
            end else if (pht_wen === 4'hF) begin
                checkOutput("sweep_addr", pht_waddr, 32'(f_cycles));
                checkOutput("sweep_data", pht_wdata, 2'b10);
                checkOutput("sweep_rdy0", upd0_ready, 0);
                f_cycles++;
            end
        end
        if (!fell) begin
            n_checks++;
            n_errors++;
            $display("[TB] FAIL init_timeout: init_busy still %0b, required 0", init_busy);
        end
        checkOutput("sweep_len", f_cycles, ITEMS);
        @(posedge clk);
        #1;
    endtask

    task automatic directedWrite(input string name, input logic [31:0] a, input logic [1:0] c, input logic t,
                                 input logic [3:0] wen, input logic [7:0] addr, input logic [1:0] data);
        applyStimulus(1'b1, a, c, t, 1'b0, '0, '0, 1'b0);
        idle(1);
        @(negedge clk);
        checkOutput({name, "_wen"}, pht_wen, wen);
        checkOutput({name, "_waddr"}, pht_waddr, addr);
        checkOutput({name, "_wdata"}, pht_wdata, data);
        checkOutput({name, "_wvld"}, pht_wvld, 1);
        @(posedge clk);
        #1;
        idle(2);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish, required completion");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        repeat (3) @(posedge clk);
        #1;
        check_en = 1'b1;
        @(negedge clk);
        checkOutput("reset_wen", pht_wen, 0);
        checkOutput("reset_waddr", pht_waddr, 0);
        checkOutput("reset_wdata", pht_wdata, 0);
        checkOutput("reset_wvld", pht_wvld, 0);
        checkOutput("reset_init_busy", init_busy, 1);
        checkOutput("reset_rdy0", upd0_ready, 0);
        checkOutput("reset_rdy1", upd1_ready, 0);
        @(posedge clk);
        #1;
        rst = 1'b1;
        waitInit();

        // Saturation and mapping
        idle(2);
        directedWrite("sat_taken", 32'h0000_1234, 2'd3, 1'b1, 4'b0010, 8'h22, 2'd3);
        directedWrite("sat_ntaken", 32'h0000_5678, 2'd0, 1'b0, 4'b0100, 8'h62, 2'd0);
        directedWrite("inc_taken", 32'h0001_2340, 2'd1, 1'b1, 4'b0001, 8'h26, 2'd2);

        // Dual enqueue with a single free slot
        idle(3);
        randomPair(1'b1, 1'b1);
        randomPair(1'b1, 1'b1);
        setPorts(1'b1, $urandom, 2'($urandom), 1'($urandom), 1'b1, $urandom, 2'($urandom), 1'($urandom));
        @(negedge clk);
        checkOutput("one_free_rdy0", upd0_ready, 1);
        checkOutput("one_free_rdy1", upd1_ready, 0);
        @(posedge clk);
        #1;
        idle(8);

        // Sustained backpressure
        acc_cnt = 0;
        wr_cnt  = 0;
        for (int i = 0; i < 20; i++) randomPair(1'b1, 1'b1);
        idle(10);
        checkOutput("backpressure_no_loss", wr_cnt, acc_cnt);

        // Pointer wrap with alternating single requests
        acc_cnt = 0;
        wr_cnt  = 0;
        for (int i = 0; i < 3 * DEPTH + 1; i++) randomPair(i % 2 == 0, i % 2 == 1);
        idle(6);
        checkOutput("wrap_accepted", acc_cnt, 3 * DEPTH + 1);
        checkOutput("wrap_written", wr_cnt, 3 * DEPTH + 1);
        @(negedge clk);
        checkOutput("wrap_empty_wen", pht_wen, 0);
        @(posedge clk);
        #1;

        // Reset with three entries queued
        idle(4);
        randomPair(1'b1, 1'b1);
        randomPair(1'b1, 1'b1);
        upd0_valid = 1'b0;
        upd1_valid = 1'b0;
        rst = 1'b0;
        @(posedge clk);
        @(negedge clk);
        checkOutput("reset_midop_wen", pht_wen, 0);
        @(posedge clk);
        #1;
        rst = 1'b1;
        waitInit();

        // Randomized traffic
        acc_cnt = 0;
        wr_cnt  = 0;
        for (int i = 0; i < 300; i++) randomPair(1'($urandom), 1'($urandom));
        idle(10);
        checkOutput("random_no_loss", wr_cnt, acc_cnt);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
